// File: rtl/video_timing_gen_p.sv
// Raster timing generator: frame/line counters over latched timing parameters, producing
// registered sync, data-enable, coordinates and an early (LEAD-cycle) enable/x for sources.
module video_timing_gen_p #(
    parameter int unsigned CNT_W  = 12,
    parameter int unsigned LEAD   = 2,
    parameter bit          HS_POL = 1'b1,
    parameter bit          VS_POL = 1'b1
) (
    input  logic             I_pxl_clk,
    input  logic             I_rst,
    input  logic             I_en,
    input  logic             I_mode,
    input  logic [CNT_W-1:0] I_h_total,
    input  logic [CNT_W-1:0] I_h_sync,
    input  logic [CNT_W-1:0] I_h_bporch,
    input  logic [CNT_W-1:0] I_h_res,
    input  logic [CNT_W-1:0] I_v_total,
    input  logic [CNT_W-1:0] I_v_sync,
    input  logic [CNT_W-1:0] I_v_bporch,
    input  logic [CNT_W-1:0] I_v_res,
    output logic             O_busy,
    output logic             O_hs,
    output logic             O_vs,
    output logic             O_de,
    output logic [CNT_W-1:0] O_x,
    output logic [CNT_W-1:0] O_y,
    output logic             O_pre_de,
    output logic [CNT_W-1:0] O_pre_x,
    output logic             O_frame_start,
    output logic             O_line_start,
    output logic             O_cfg_err
);

    localparam int unsigned SW = CNT_W + 2;

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e state_q, state_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic busy_q, busy_d, err_q, err_d;
    logic latch;

    logic [CNT_W-1:0] h_total_q, h_sync_q, h_bporch_q, h_res_q;
    logic [CNT_W-1:0] v_total_q, v_sync_q, v_bporch_q, v_res_q;

    // Start validation on the live inputs, widened so the sums cannot wrap
    logic [SW-1:0] in_h_blank, in_h_sum, in_v_sum;
    logic          cfg_ok;

    always_comb begin
        in_h_blank = SW'(I_h_sync) + SW'(I_h_bporch);
        in_h_sum   = in_h_blank + SW'(I_h_res);
        in_v_sum   = SW'(I_v_sync) + SW'(I_v_bporch) + SW'(I_v_res);
        cfg_ok     = (in_h_sum <= SW'(I_h_total)) && (in_v_sum <= SW'(I_v_total)) &&
                     (I_h_res != '0) && (I_v_res != '0) &&
                     (I_h_sync != '0) && (I_v_sync != '0) &&
                     (SW'(LEAD) <= in_h_blank);
    end

    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        busy_d  = busy_q;
        err_d   = err_q;
        latch   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (I_en) begin
                    if (cfg_ok) begin
                        latch   = 1'b1;
                        state_d = StRun;
                        h_cnt_d = '0;
                        v_cnt_d = '0;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (h_cnt_q == h_total_q - 1'b1) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == v_total_q - 1'b1) begin
                        v_cnt_d = '0;
                        if (I_mode && I_en && cfg_ok) begin
                            latch = 1'b1;
                            err_d = 1'b0;
                        end else begin
                            state_d = StFinish;
                            if (I_mode && I_en) begin
                                err_d = 1'b1;
                            end
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + 1'b1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 1'b1;
                end
            end
            StFinish: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode of the current counter position; registered below
    logic [SW-1:0] h_w, v_w, ph_w, h_beg, h_end, v_beg, v_end;
    logic run, in_h, in_v, pre_in_h;
    logic hs_d, vs_d, de_d, pre_de_d, fs_d, ls_d;
    logic [CNT_W-1:0] x_d, y_d, pre_x_d;

    always_comb begin
        run      = (state_q == StRun);
        h_w      = SW'(h_cnt_q);
        v_w      = SW'(v_cnt_q);
        ph_w     = h_w + SW'(LEAD);
        h_beg    = SW'(h_sync_q) + SW'(h_bporch_q);
        h_end    = h_beg + SW'(h_res_q);
        v_beg    = SW'(v_sync_q) + SW'(v_bporch_q);
        v_end    = v_beg + SW'(v_res_q);
        in_h     = (h_w >= h_beg) && (h_w < h_end);
        in_v     = (v_w >= v_beg) && (v_w < v_end);
        // Positions past h_total land in the next line's blanking, since LEAD <= h_beg
        pre_in_h = (ph_w >= h_beg) && (ph_w < h_end);
        hs_d     = (run && (h_cnt_q < h_sync_q)) ? HS_POL : !HS_POL;
        vs_d     = (run && (v_cnt_q < v_sync_q)) ? VS_POL : !VS_POL;
        de_d     = run && in_h && in_v;
        pre_de_d = run && pre_in_h && in_v;
        x_d      = de_d ? CNT_W'(h_w - h_beg) : '0;
        y_d      = de_d ? CNT_W'(v_w - v_beg) : '0;
        pre_x_d  = pre_de_d ? CNT_W'(ph_w - h_beg) : '0;
        ls_d     = run && (h_cnt_q == '0);
        fs_d     = ls_d && (v_cnt_q == '0);
    end

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            state_q       <= StIdle;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            h_total_q     <= '0;
            h_sync_q      <= '0;
            h_bporch_q    <= '0;
            h_res_q       <= '0;
            v_total_q     <= '0;
            v_sync_q      <= '0;
            v_bporch_q    <= '0;
            v_res_q       <= '0;
            O_hs          <= !HS_POL;
            O_vs          <= !VS_POL;
            O_de          <= 1'b0;
            O_x           <= '0;
            O_y           <= '0;
            O_pre_de      <= 1'b0;
            O_pre_x       <= '0;
            O_frame_start <= 1'b0;
            O_line_start  <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            if (latch) begin
                h_total_q  <= I_h_total;
                h_sync_q   <= I_h_sync;
                h_bporch_q <= I_h_bporch;
                h_res_q    <= I_h_res;
                v_total_q  <= I_v_total;
                v_sync_q   <= I_v_sync;
                v_bporch_q <= I_v_bporch;
                v_res_q    <= I_v_res;
            end
            O_hs          <= hs_d;
            O_vs          <= vs_d;
            O_de          <= de_d;
            O_x           <= x_d;
            O_y           <= y_d;
            O_pre_de      <= pre_de_d;
            O_pre_x       <= pre_x_d;
            O_frame_start <= fs_d;
            O_line_start  <= ls_d;
        end
    end

    assign O_busy    = busy_q;
    assign O_cfg_err = err_q;

endmodule

// File: tb/tb_video_timing_gen_p.sv
// Cycle-accurate bench: a reference raster model queues the expected output word for every
// clock edge, which is compared against the DUT just after that edge.
module tb_video_timing_gen_p;

    localparam int unsigned W    = 12;
    localparam int unsigned LD   = 2;
    localparam bit          HS_P = 1'b0;
    localparam bit          VS_P = 1'b1;

    logic clk = 1'b0;
    logic rst, en, mode;
    logic [W-1:0] h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
    logic busy, hs, vs, de, pre_de, fs, ls, cfg_err;
    logic [W-1:0] x, y, pre_x;

    always #5 clk = ~clk;

    video_timing_gen_p #(
        .CNT_W (W),
        .LEAD  (LD),
        .HS_POL(HS_P),
        .VS_POL(VS_P)
    ) dut (
        .I_pxl_clk    (clk),
        .I_rst        (rst),
        .I_en         (en),
        .I_mode       (mode),
        .I_h_total    (h_total),
        .I_h_sync     (h_sync),
        .I_h_bporch   (h_bporch),
        .I_h_res      (h_res),
        .I_v_total    (v_total),
        .I_v_sync     (v_sync),
        .I_v_bporch   (v_bporch),
        .I_v_res      (v_res),
        .O_busy       (busy),
        .O_hs         (hs),
        .O_vs         (vs),
        .O_de         (de),
        .O_x          (x),
        .O_y          (y),
        .O_pre_de     (pre_de),
        .O_pre_x      (pre_x),
        .O_frame_start(fs),
        .O_line_start (ls),
        .O_cfg_err    (cfg_err)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int de_cnt  = 0;
    int fs_cnt  = 0;

    logic [43:0] exp_q[$];

    // Reference model state: 0 idle, 1 run, 2 finish
    int m_st = 0, mh = 0, mv = 0;
    int s_ht = 0, s_hs = 0, s_hb = 0, s_hr = 0, s_vt = 0, s_vs = 0, s_vb = 0, s_vr = 0;
    bit m_busy = 1'b0, m_err = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic bit cfg_good();
        int hs_i = int'(h_sync), hb_i = int'(h_bporch);
        return (hs_i + hb_i + int'(h_res) <= int'(h_total)) &&
               (int'(v_sync) + int'(v_bporch) + int'(v_res) <= int'(v_total)) &&
               (h_res != 0) && (v_res != 0) && (h_sync != 0) && (v_sync != 0) &&
               (int'(LD) <= hs_i + hb_i);
    endfunction

    task automatic latch_cfg();
        s_ht = int'(h_total); s_hs = int'(h_sync); s_hb = int'(h_bporch); s_hr = int'(h_res);
        s_vt = int'(v_total); s_vs = int'(v_sync); s_vb = int'(v_bporch); s_vr = int'(v_res);
    endtask

    function automatic bit active(int h, int v);
        return (h >= s_hs + s_hb) && (h < s_hs + s_hb + s_hr) &&
               (v >= s_vs + s_vb) && (v < s_vs + s_vb + s_vr);
    endfunction

    task automatic tick();
        bit run, e_hs, e_vs, e_de, e_pde, e_fs, e_ls;
        int ex, ey, epx, p, hq, vq;
        logic [43:0] dut_word;
        @(posedge clk);
        run   = (m_st == 1);
        e_de  = run && active(mh, mv);
        e_hs  = (run && mh < s_hs) ? HS_P : !HS_P;
        e_vs  = (run && mv < s_vs) ? VS_P : !VS_P;
        ex    = e_de ? mh - (s_hs + s_hb) : 0;
        ey    = e_de ? mv - (s_vs + s_vb) : 0;
        // Early outputs: look LEAD positions ahead along the linear raster order
        p     = mv * s_ht + mh + int'(LD);
        e_pde = 1'b0;
        epx   = 0;
        if (run && p < s_ht * s_vt) begin
            hq    = p % s_ht;
            vq    = p / s_ht;
            e_pde = active(hq, vq);
            epx   = e_pde ? hq - (s_hs + s_hb) : 0;
        end
        e_ls = run && (mh == 0);
        e_fs = e_ls && (mv == 0);
        if (rst) begin
            m_st = 0; mh = 0; mv = 0; m_busy = 0; m_err = 0;
            e_hs = !HS_P; e_vs = !VS_P; e_de = 0; e_pde = 0; e_fs = 0; e_ls = 0;
            ex = 0; ey = 0; epx = 0;
        end else begin
            case (m_st)
                0: if (en) begin
                    if (cfg_good()) begin
                        latch_cfg(); m_st = 1; mh = 0; mv = 0; m_busy = 1; m_err = 0;
                    end else begin
                        m_err = 1;
                    end
                end
                1: begin
                    if (mh == s_ht - 1 && mv == s_vt - 1) begin
                        mh = 0; mv = 0;
                        if (mode && en && cfg_good()) begin
                            latch_cfg(); m_err = 0;
                        end else begin
                            m_st = 2;
                            if (mode && en) m_err = 1;
                        end
                    end else if (mh == s_ht - 1) begin
                        mh = 0; mv++;
                    end else begin
                        mh++;
                    end
                end
                default: begin
                    m_st = 0; m_busy = 0;
                end
            endcase
        end
        exp_q.push_back({m_busy, m_err, e_hs, e_vs, e_de, e_pde, e_fs, e_ls,
                         W'(ex), W'(ey), W'(epx)});
        #1;
        dut_word = {busy, cfg_err, hs, vs, de, pre_de, fs, ls, x, y, pre_x};
        check_val($sformatf("out@%0d", cyc), 64'(dut_word), 64'(exp_q.pop_front()));
        if (de) de_cnt++;
        if (fs) fs_cnt++;
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cfg(input int ht, hs_v, hb, hr, vt, vs_v, vb, vr);
        h_total = W'(ht); h_sync = W'(hs_v); h_bporch = W'(hb); h_res = W'(hr);
        v_total = W'(vt); v_sync = W'(vs_v); v_bporch = W'(vb); v_res = W'(vr);
    endtask

    task automatic pulse_en();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0;
        set_cfg(20, 3, 2, 10, 12, 2, 1, 6);
        run_cycles(3);
        rst = 1'b0;
        run_cycles(3);

        // Single frame: 20x12 = 240 cycles of RUN plus FINISH
        de_cnt = 0; fs_cnt = 0;
        pulse_en();
        run_cycles(250);
        check_val("de_count_single", 64'(de_cnt), 64'(60));
        check_val("fs_count_single", 64'(fs_cnt), 64'(1));

        // Rejected starts: h sum too large, zero v_res, LEAD beyond h blanking
        set_cfg(20, 3, 2, 20, 12, 2, 1, 6);
        pulse_en();
        run_cycles(3);
        set_cfg(20, 3, 2, 10, 12, 2, 1, 0);
        pulse_en();
        run_cycles(3);
        set_cfg(20, 1, 0, 5, 12, 2, 1, 6);
        pulse_en();
        run_cycles(3);
        set_cfg(20, 3, 2, 10, 12, 2, 1, 6);
        pulse_en();
        run_cycles(250);

        // Continuous mode with a mid-frame h_res change taking effect on the next frame
        mode = 1'b1; en = 1'b1; de_cnt = 0; fs_cnt = 0;
        run_cycles(100);
        h_res = W'(8);
        run_cycles(140);
        check_val("de_count_cont_f1", 64'(de_cnt), 64'(60));
        de_cnt = 0;
        run_cycles(240);
        check_val("de_count_cont_f2", 64'(de_cnt), 64'(48));
        check_val("fs_count_cont", 64'(fs_cnt), 64'(2));

        // Invalid config at frame wrap ends continuous run with cfg_err set
        h_res = W'(20);
        run_cycles(250);
        set_cfg(20, 3, 2, 10, 12, 2, 1, 6);
        run_cycles(120);

        // Mid-frame reset, then a fresh single-frame start from (0,0)
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0; mode = 1'b0;
        run_cycles(3);
        de_cnt = 0;
        pulse_en();
        run_cycles(250);
        check_val("de_count_after_rst", 64'(de_cnt), 64'(60));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/video_timing_gen_p.md
VIDEO_TIMING_GEN_P -- requirements
Module: video_timing_gen_p

Interface
REQ-001 Parameter CNT_W, default 12, width of all timing inputs, counters and coordinate outputs.
REQ-002 Parameter LEAD, default 2, cycles by which O_pre_de/O_pre_x lead O_de/O_x; legal range 0..15.
REQ-003 Parameter HS_POL, default 1, active level of O_hs; VS_POL, default 1, active level of O_vs.
REQ-004 I_pxl_clk  in  1  pixel clock; the only clock.
REQ-005 I_rst  in  1  synchronous, active-high reset.
REQ-006 I_en  in  1  start request; sampled in IDLE and at each frame end.
REQ-007 I_mode  in  1  0 = single frame per start, 1 = continuous while I_en high.
REQ-008 I_h_total, I_h_sync, I_h_bporch, I_h_res  in  CNT_W each  horizontal timing in pixels.
REQ-009 I_v_total, I_v_sync, I_v_bporch, I_v_res  in  CNT_W each  vertical timing in lines.
REQ-010 O_busy  out  1  high from accepted start until return to IDLE.
REQ-011 O_hs, O_vs, O_de  out  1  registered sync and data-enable.
REQ-012 O_x, O_y  out  CNT_W  active-pixel coordinates, aligned with O_de.
REQ-013 O_pre_de  out  1, O_pre_x  out  CNT_W  early enable/x for pipelined pixel sources.
REQ-014 O_frame_start  out  1  one-cycle pulse on first cycle of each frame.
REQ-015 O_line_start  out  1  one-cycle pulse on first cycle of each line.
REQ-016 O_cfg_err  out  1  high while the last start request was rejected.

Function
REQ-017 States SHALL be IDLE, RUN, FINISH; reset enters IDLE.
REQ-018 Timing inputs SHALL be latched into shadow registers only on an accepted start or continuous-mode frame wrap; mid-frame input changes SHALL have no effect.
REQ-019 A start SHALL be rejected if h_sync+h_bporch+h_res > h_total, v_sync+v_bporch+v_res > v_total, any of h_res/v_res/h_sync/v_sync = 0, or LEAD > h_sync+h_bporch; sums SHALL be computed CNT_W+2 bits wide (no wrap).
REQ-020 IDLE: I_en=1 and config valid -> RUN, latch, h_cnt=v_cnt=0, O_cfg_err<=0; invalid -> stay IDLE, O_cfg_err<=1; I_en=0 -> stay, O_cfg_err holds.
REQ-021 RUN: h_cnt counts 0..h_total-1 then wraps to 0 and increments v_cnt; v_cnt counts 0..v_total-1.
REQ-022 At h_cnt=h_total-1, v_cnt=v_total-1: if I_mode=1, I_en=1 and new config valid -> stay RUN, relatch, counters to 0; otherwise -> FINISH (invalid config also sets O_cfg_err).
REQ-023 FINISH SHALL last exactly one cycle then enter IDLE with O_busy<=0.
REQ-024 All outputs SHALL be registered, one cycle after the counter value they decode.
REQ-025 O_hs active when h_cnt < h_sync; O_vs active when v_cnt < v_sync; inactive level = inverse of HS_POL/VS_POL.
REQ-026 O_de = 1 when h_cnt in [h_sync+h_bporch, h_sync+h_bporch+h_res-1] and v_cnt in [v_sync+v_bporch, v_sync+v_bporch+v_res-1].
REQ-027 O_x = h_cnt-(h_sync+h_bporch), O_y = v_cnt-(v_sync+v_bporch) when O_de=1; both 0 otherwise.
REQ-028 O_pre_de/O_pre_x SHALL equal O_de/O_x as they will be LEAD cycles later; LEAD=0 makes them identical.
REQ-029 O_frame_start pulses for counter state (0,0); O_line_start pulses for every h_cnt=0 in RUN.
REQ-030 Outside RUN, O_de, O_pre_de, pulses = 0, O_hs/O_vs inactive, O_x/O_y/O_pre_x = 0.

Reset
REQ-031 I_rst=1 at any clock edge, including mid-frame, SHALL force IDLE, counters 0, O_busy=0, O_cfg_err=0, and all outputs to REQ-030 values on that edge; I_rst dominates I_en.

Verification
REQ-032 800x600 (1056/128/88/800, 628/4/23/600), I_mode=0, I_en pulse -> one frame, O_de high 800 cycles x 600 lines, first O_de at cycle 216 of line 27 with O_x=0,O_y=0, O_busy low after 1056*628+1 cycles.
REQ-033 Same timing, I_mode=1, I_en held -> back-to-back frames, O_frame_start every 663168 cycles, no FINISH gap.
REQ-034 Change I_h_res to 640 mid-frame, continuous -> current frame keeps 800 active pixels, next frame shows 640.
REQ-035 Start with h_res=1000 (sum 1216 > 1056) -> O_busy stays 0, O_cfg_err=1; valid start then clears it.
REQ-036 LEAD=2 -> O_pre_de rises 2 cycles before O_de, O_pre_x=0 two cycles before O_x=0; HS_POL=0 -> O_hs low for 128 cycles per line.
REQ-037 I_rst asserted at line 300 -> next edge O_de=0, O_busy=0, O_hs/O_vs inactive; new I_en restarts at (0,0).
